// File: rtl/bcd_rtc_counter.sv
// BCD time-of-day counter (HH:MM:SS) with a 1 Hz prescaler, 12/24-hour display and validated time load.
// Define ALARM_EN to add the alarm compare (alarm_time, alarm_arm, alarm_hit).
module bcd_rtc_counter #(
    parameter int CLK_FREQ = 50000000,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clc,
    input  logic        run,
    input  logic        sec_up,
    input  logic        min_up,
    input  logic        hour_up,
    input  logic        mode_12h,
    input  logic        load,
    input  logic [23:0] load_time,
`ifdef ALARM_EN
    input  logic [23:0] alarm_time,
    input  logic        alarm_arm,
    output logic        alarm_hit,
`endif
    output logic [23:0] clock_time,
    output logic        pm,
    output logic        sec_tick,
    output logic        load_err
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CLK_FREQ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [7:0]       sec_q, sec_n;
    logic [7:0]       min_q, min_n;
    logic [7:0]       hour_q, hour_n;
    logic             term;
    logic             load_ok;
    logic             err_n;
    logic             tick_apply;
    logic             any_set;
    logic [7:0]       hour_disp;

    function automatic logic [7:0] inc_60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] inc_24(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic ok_60(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic ok_24(input logic [7:0] v);
        return (v[3:0] <= 4'd9) &&
               ((v[7:4] <= 4'd1) || ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3)));
    endfunction

    assign term    = run && (cnt_q == TERM_CNT);
    assign load_ok = ok_24(load_time[23:16]) && ok_60(load_time[15:8]) && ok_60(load_time[7:0]);
    assign any_set = sec_up || min_up || hour_up;

    // Prescaler: a rejected load does not restart the second.
    always_comb begin
        cnt_n = cnt_q;
        if (clc || (load && load_ok) || sec_up) begin
            cnt_n = '0;
        end else if (run) begin
            cnt_n = term ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        sec_n      = sec_q;
        min_n      = min_q;
        hour_n     = hour_q;
        err_n      = 1'b0;
        tick_apply = 1'b0;
        if (clc) begin
            sec_n  = 8'h00;
            min_n  = 8'h00;
            hour_n = 8'h00;
        end else if (load) begin
            if (load_ok) begin
                hour_n = load_time[23:16];
                min_n  = load_time[15:8];
                sec_n  = load_time[7:0];
            end else begin
                err_n = 1'b1;
            end
        end else if (any_set) begin
            if (sec_up)  sec_n  = inc_60(sec_q);
            if (min_up)  min_n  = inc_60(min_q);
            if (hour_up) hour_n = inc_24(hour_q);
        end else if (term) begin
            tick_apply = 1'b1;
            sec_n      = inc_60(sec_q);
            if (sec_q == 8'h59) begin
                min_n = inc_60(min_q);
                if (min_q == 8'h59) begin
                    hour_n = inc_24(hour_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sec_q    <= 8'h00;
            min_q    <= 8'h00;
            hour_q   <= 8'h00;
            sec_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            cnt_q    <= cnt_n;
            sec_q    <= sec_n;
            min_q    <= min_n;
            hour_q   <= hour_n;
            sec_tick <= term;
            load_err <= err_n;
        end
    end

`ifdef ALARM_EN
    // Only a tick-driven arrival at the alarm time fires; load/set matches are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hit <= 1'b0;
        end else begin
            alarm_hit <= tick_apply && alarm_arm && ({hour_n, min_n, sec_n} == alarm_time);
        end
    end
`endif

    assign pm = (hour_q[7:4] == 4'd2) || ((hour_q[7:4] == 4'd1) && (hour_q[3:0] >= 4'd2));

    // 12-hour hour mapping done digit-wise: 13..19 -> 01..07, 20..21 -> 08..09, 22..23 -> 10..11.
    always_comb begin
        hour_disp = hour_q;
        if (mode_12h) begin
            if (hour_q == 8'h00) begin
                hour_disp = 8'h12;
            end else if (hour_q[7:4] == 4'd1 && hour_q[3:0] >= 4'd3) begin
                hour_disp = {4'd0, hour_q[3:0] - 4'd2};
            end else if (hour_q[7:4] == 4'd2) begin
                if (hour_q[3:0] <= 4'd1) begin
                    hour_disp = {4'd0, hour_q[3:0] + 4'd8};
                end else begin
                    hour_disp = {4'd1, hour_q[3:0] - 4'd2};
                end
            end
        end
    end

    assign clock_time = {hour_disp, min_q, sec_q};

endmodule

// File: tb/tb_bcd_rtc_counter.sv
// Directed bench for bcd_rtc_counter at CLK_FREQ=10: vector table for load/set/display, hand sequences for timing.
module tb_bcd_rtc_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clc, run, sec_up, min_up, hour_up, mode_12h, load;
    logic [23:0] load_time;
    logic [23:0] clock_time;
    logic        pm, sec_tick, load_err;

    int passed = 0;
    int total  = 0;

    bcd_rtc_counter #(.CLK_FREQ(10), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clc(clc), .run(run),
        .sec_up(sec_up), .min_up(min_up), .hour_up(hour_up),
        .mode_12h(mode_12h), .load(load), .load_time(load_time),
        .clock_time(clock_time), .pm(pm), .sec_tick(sec_tick), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clc, load;
        logic [23:0] lt;
        logic        su, mu, hu, m12;
        logic [23:0] et;
        logic        epm, eerr;
    } vec_t;

    vec_t vq[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    initial begin
        int ticks, first, last, bad, early;

        rst_n = 1'b0; clc = 0; run = 0; sec_up = 0; min_up = 0; hour_up = 0;
        mode_12h = 0; load = 0; load_time = '0;

        // Reset state
        #12;
        check("rst_time24", clock_time, 24'h000000);
        check("rst_pm", pm, 1'b0);
        check("rst_tick", sec_tick, 1'b0);
        check("rst_err", load_err, 1'b0);
        mode_12h = 1; #1;
        check("rst_time12", clock_time, 24'h120000);
        mode_12h = 0;
        step();
        rst_n = 1'b1;

        //            clc load lt         su mu hu m12 et         pm err
        vq.push_back('{0, 1, 24'h235958, 0, 0, 0, 0, 24'h235958, 1, 0});
        vq.push_back('{0, 1, 24'h236000, 0, 0, 0, 0, 24'h235958, 1, 1});
        vq.push_back('{0, 1, 24'h12A000, 0, 0, 0, 0, 24'h235958, 1, 1});
        vq.push_back('{0, 1, 24'h240000, 0, 0, 0, 0, 24'h235958, 1, 1});
        vq.push_back('{0, 1, 24'h105959, 0, 0, 0, 0, 24'h105959, 0, 0});
        vq.push_back('{0, 0, 24'h000000, 0, 1, 0, 0, 24'h100059, 0, 0});
        vq.push_back('{0, 1, 24'h105959, 0, 0, 0, 0, 24'h105959, 0, 0});
        vq.push_back('{0, 0, 24'h000000, 1, 1, 1, 0, 24'h110000, 0, 0});
        vq.push_back('{0, 1, 24'h235959, 0, 0, 0, 0, 24'h235959, 1, 0});
        vq.push_back('{0, 0, 24'h000000, 0, 0, 1, 0, 24'h005959, 0, 0});
        vq.push_back('{0, 0, 24'h000000, 1, 0, 0, 0, 24'h005900, 0, 0});
        vq.push_back('{0, 1, 24'h010203, 1, 0, 1, 0, 24'h010203, 0, 0});
        vq.push_back('{0, 1, 24'h000000, 0, 0, 0, 1, 24'h120000, 0, 0});
        vq.push_back('{0, 1, 24'h130501, 0, 0, 0, 1, 24'h010501, 1, 0});
        vq.push_back('{0, 0, 24'h000000, 0, 0, 0, 0, 24'h130501, 1, 0});
        vq.push_back('{0, 1, 24'h120000, 0, 0, 0, 1, 24'h120000, 1, 0});
        vq.push_back('{0, 1, 24'h220000, 0, 0, 0, 1, 24'h100000, 1, 0});
        vq.push_back('{0, 1, 24'h200000, 0, 0, 0, 1, 24'h080000, 1, 0});
        vq.push_back('{0, 1, 24'h010000, 0, 0, 0, 1, 24'h010000, 0, 0});
        vq.push_back('{1, 1, 24'h235958, 0, 0, 0, 0, 24'h000000, 0, 0});
        vq.push_back('{0, 1, 24'h125959, 0, 0, 0, 0, 24'h125959, 1, 0});
        vq.push_back('{1, 1, 24'h236000, 0, 0, 0, 0, 24'h000000, 0, 0});
        vq.push_back('{0, 1, 24'h00005A, 0, 0, 0, 0, 24'h000000, 0, 1});

        foreach (vq[i]) begin
            clc = vq[i].clc; load = vq[i].load; load_time = vq[i].lt;
            sec_up = vq[i].su; min_up = vq[i].mu; hour_up = vq[i].hu; mode_12h = vq[i].m12;
            step();
            check($sformatf("vec%0d_time", i), clock_time, vq[i].et);
            check($sformatf("vec%0d_pm", i), pm, vq[i].epm);
            check($sformatf("vec%0d_err", i), load_err, vq[i].eerr);
        end
        clc = 0; load = 0; sec_up = 0; min_up = 0; hour_up = 0; mode_12h = 0;
        step();
        check("err_one_cycle", load_err, 1'b0);

        // Mode change visible without a clock edge
        load = 1; load_time = 24'h130501; step(); load = 0;
        mode_12h = 1; #1;
        check("mode_12_comb", clock_time, 24'h010501);
        mode_12h = 0; #1;
        check("mode_24_comb", clock_time, 24'h130501);

        // Day rollover through ticks
        load = 1; load_time = 24'h235958; step(); load = 0;
        run = 1;
        repeat (10) step();
        check("roll_59", clock_time, 24'h235959);
        check("roll_59_pm", pm, 1'b1);
        repeat (10) step();
        check("roll_00", clock_time, 24'h000000);
        check("roll_00_pm", pm, 1'b0);

        // Set button on the terminal cycle suppresses the tick
        repeat (9) step();
        min_up = 1; step(); min_up = 0;
        check("set_supp_tick", clock_time, 24'h000100);

        // Pause: prescaler and time frozen
        repeat (5) step();
        run = 0;
        early = 0;
        repeat (25) begin step(); if (sec_tick) early++; end
        check("pause_no_tick", early, 0);
        check("pause_time", clock_time, 24'h000100);
        run = 1;
        early = 0;
        repeat (4) begin step(); if (sec_tick) early++; end
        check("pause_resume_early", early, 0);
        step();
        check("pause_resume_tick", sec_tick, 1'b1);
        check("pause_resume_time", clock_time, 24'h000101);

        // sec_up restarts the prescaler
        repeat (5) step();
        sec_up = 1; step(); sec_up = 0;
        check("secup_time", clock_time, 24'h000102);
        early = 0;
        repeat (9) begin step(); if (sec_tick) early++; end
        check("secup_no_early", early, 0);
        step();
        check("secup_tick", sec_tick, 1'b1);
        check("secup_tick_time", clock_time, 24'h000103);

        // 600 ticks from a clear
        run = 0; clc = 1; step(); clc = 0;
        check("clc_time", clock_time, 24'h000000);
        run = 1;
        ticks = 0; first = -1; last = 0; bad = 0;
        for (int c = 1; c <= 6000; c++) begin
            step();
            if (sec_tick) begin
                if (first < 0) first = c;
                else if (c - last != 10) bad++;
                last = c;
                ticks++;
            end
        end
        check("run_first_tick", first, 10);
        check("run_tick_count", ticks, 600);
        check("run_tick_spacing", bad, 0);
        check("run_600s", clock_time, 24'h001000);

        // Asynchronous reset mid-count
        repeat (7) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_time", clock_time, 24'h000000);
        check("arst_tick", sec_tick, 1'b0);
        step();
        rst_n = 1'b1;
        early = 0;
        repeat (9) begin step(); if (sec_tick) early++; end
        check("arst_no_early", early, 0);
        step();
        check("arst_tick_10", sec_tick, 1'b1);
        check("arst_time_1s", clock_time, 24'h000001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bcd_rtc_counter.md
Name: bcd_rtc_counter

Overview:
- Parametrised successor to the board's BCD time-of-day counter: free-running seconds/minutes/hours kept in packed BCD, driven by a 1 Hz prescaler from the system clock.
- Adds runtime 12/24-hour display and a validated parallel time load.
- Set buttons wrap within their own field instead of rippling.
- Output feeds the 7-segment display driver directly; set/run/clear inputs come from the debounced key block.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz; prescaler terminal count is CLK_FREQ-1.
- CNT_W, 32, prescaler counter width; must satisfy 2^CNT_W > CLK_FREQ.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clc  in  1  synchronous clear of time and prescaler.
- run  in  1  level; 1 = time advances on prescaler tick, 0 = paused.
- sec_up  in  1  single-cycle pulse; seconds +1 with field wrap.
- min_up  in  1  single-cycle pulse; minutes +1 with field wrap.
- hour_up  in  1  single-cycle pulse; hours +1 with field wrap.
- mode_12h  in  1  level; 1 = 12-hour display, 0 = 24-hour display.
- load  in  1  single-cycle pulse; load load_time.
- load_time  in  24  BCD {HH,MM,SS}, always 24-hour encoding.
- clock_time  out  24  BCD {H10,H1,M10,M1,S10,S1}, bits [23:20] down to [3:0].
- pm  out  1  1 when internal hour is 12..23 (valid in both modes).
- sec_tick  out  1  1-cycle pulse on every prescaler terminal count while run=1.
- load_err  out  1  1-cycle pulse when a load is rejected.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset: internal time 00:00:00, prescaler 0, sec_tick=0, load_err=0. clock_time reads 000000 in 24h mode and 120000 in 12h mode, with pm=0.
- Prescaler:
  - Counts 0..CLK_FREQ-1 and wraps.
  - Counts only while run=1; holds its value while run=0.
  - Cleared to 0 in any cycle with clc, an accepted load, or sec_up.
  - sec_tick=1 in the cycle after the counter equals CLK_FREQ-1 with run=1 (registered).
- Internal time is kept in 24-hour BCD. Each digit is always a legal value: S1/M1/H1 ≤9, S10/M10 ≤5, hour ≤23. No transient 10 or 60 values ever appear; carries resolve in the same cycle.
- Priority per cycle: rst_n > clc > load > set buttons > tick.
- clc: time becomes 00:00:00 on the next edge.
- load:
  - Accepted only if every nibble ≤9, SS ≤59, MM ≤59 and HH ≤23; time takes load_time on the next edge.
  - Otherwise time is unchanged and load_err pulses for 1 cycle.
  - Set buttons and tick are ignored in a load cycle.
- Set buttons:
  - Each button independently increments its own field: 59→00, 23→00. No carry into the next field.
  - Simultaneous buttons all apply in the same cycle.
  - The tick is suppressed in any cycle where any set button is active.
- Tick (the prescaler terminal cycle with run=1):
  - Seconds +1.
  - At 59, seconds go to 00 and carry into minutes.
  - Minute 59 carries into hour.
  - 23:59:59 → 00:00:00.
- Display mapping (combinational from internal registers and mode_12h; a mode change is visible the same cycle):
  - mode_12h=0: hour field = internal hour.
  - mode_12h=1: hour 0→12; 1..12 unchanged; 13..23 → hour-12.
- Held button level: a button held for N cycles increments N times. The debouncer guarantees single-cycle pulses.
- Reset asserted mid-count: all state clears immediately and asynchronously. Counting resumes from 0 on the first edge after release.

Optional Feature:
- ALARM_EN defined:
  - Adds inputs alarm_time[23:0] (24h BCD) and alarm_arm (level), and output alarm_hit.
  - alarm_hit is a 1-cycle pulse in the cycle after the internal time becomes equal to alarm_time through a tick, while alarm_arm=1.
  - Equality reached by load or set buttons does not fire the alarm.
- ALARM_EN undefined: these ports and the compare logic are absent; everything else is identical.

Test Plan (CLK_FREQ=10):
- Reset, run=1, 600 ticks → clock_time goes 000000 → 001000; sec_tick pulses exactly every 10 cycles.
- load 235958, run=1, 2 ticks → 235959 then 000000; pm goes from 1 to 0.
- load 236000 → time unchanged, load_err=1 for 1 cycle; load 12A000 → rejected the same way.
- Time 105959, pulse min_up → 100059 (no hour carry); pulse sec_up+min_up+hour_up together → 110000.
- mode_12h=1: time 000000 reads 120000 pm=0; time 130501 reads 010501 pm=1; toggle mode_12h → 130501 visible the same cycle.
- run=0 for 25 cycles → time and prescaler frozen. clc in the same cycle as load → 000000 and load_err=0. Assert rst_n low mid-count → immediate clear.
